// File: rtl/multipath_channel.sv
// multipath_channel: programmable multi-tap echo channel with attenuation,
// optional LFSR noise (enable with MULTIPATH_NOISE_EN) and output saturation.
module multipath_channel #(
  parameter int SYM_W             = 2,
  parameter int OUT_W             = 14,
  parameter int DEPTH             = 16,
  parameter int NTAPS             = 4,
  parameter int GAIN_W            = 8,
  parameter int ATTEN_SHIFT       = 6,
  parameter int NOISE_W           = 6,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic signed [SYM_W-1:0]                 in_sym,
  input  logic                                    cfg_we,
  input  logic [(NTAPS>1?$clog2(NTAPS):1)-1:0]    cfg_tap,
  input  logic [$clog2(DEPTH)-1:0]                cfg_delay,
  input  logic signed [GAIN_W-1:0]                cfg_gain,
  output logic                                    out_valid,
  output logic signed [OUT_W-1:0]                 out_sample,
  output logic                                    sat_flag
);

  localparam int DW = $clog2(DEPTH);
  localparam int KW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam int PW = SYM_W + GAIN_W;
  localparam int AW = SYM_W + GAIN_W + $clog2(NTAPS) + 1;
  localparam int SW = ((AW > NOISE_W) ? AW : NOISE_W) + 1;
  localparam int CW = ((SW > OUT_W) ? SW : OUT_W) + 1;

  localparam logic signed [GAIN_W-1:0] UNITY = GAIN_W'(1 << ATTEN_SHIFT);
  localparam logic signed [CW-1:0] MAXV =
    {{(CW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [CW-1:0] MINV = ~MAXV;

  if (LFSR_SEED == 16'h0 || DEPTH < 2 ||
      (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
    $error("multipath_channel: illegal parameters");
  end

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    SCALE,
    OUT
  } state_t;

  state_t state, state_nx;

  logic signed [SYM_W-1:0]  dline [DEPTH];
  logic [DW-1:0]            wptr;
  logic [DW-1:0]            base;
  logic [KW-1:0]            k;
  logic [DW-1:0]            sh_dly  [NTAPS];
  logic signed [GAIN_W-1:0] sh_gain [NTAPS];
  logic [DW-1:0]            ac_dly  [NTAPS];
  logic signed [GAIN_W-1:0] ac_gain [NTAPS];
  logic [DW-1:0]            nx_dly  [NTAPS];
  logic signed [GAIN_W-1:0] nx_gain [NTAPS];
  logic signed [AW-1:0]     acc;
  logic signed [SW-1:0]     s;
  logic signed [SW-1:0]     shifted;
  logic signed [CW-1:0]     sx;
  logic signed [PW-1:0]     prod;
  logic signed [NOISE_W-1:0] noise;
  logic signed [OUT_W-1:0]  clamp;
  logic                     sat_nx;
  logic [DW-1:0]            rd_idx;
  logic                     accept;
  logic                     last_k;

  assign accept  = in_valid && in_ready;
  assign last_k  = (k == KW'(NTAPS - 1));
  assign rd_idx  = base - ac_dly[k];
  assign prod    = PW'(dline[rd_idx]) * PW'(ac_gain[k]);
  assign shifted = SW'(acc >>> ATTEN_SHIFT);
  assign sx      = CW'(s);

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // next state and handshake
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = ACCUM;
      end
      ACCUM:   if (last_k) state_nx = SCALE;
      SCALE:   state_nx = OUT;
      OUT:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // shadow taps with this cycle's write folded in
  always_comb begin
    for (int i = 0; i < NTAPS; i++) begin
      nx_dly[i]  = sh_dly[i];
      nx_gain[i] = sh_gain[i];
      if (cfg_we && cfg_tap == KW'(i)) begin
        nx_dly[i]  = cfg_delay;
        nx_gain[i] = cfg_gain;
      end
    end
  end

  // shadow and active tap registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NTAPS; i++) begin
        sh_dly[i]  <= '0;
        sh_gain[i] <= (i == 0) ? UNITY : '0;
        ac_dly[i]  <= '0;
        ac_gain[i] <= (i == 0) ? UNITY : '0;
      end
    end else begin
      for (int i = 0; i < NTAPS; i++) begin
        sh_dly[i]  <= nx_dly[i];
        sh_gain[i] <= nx_gain[i];
        if (accept) begin
          ac_dly[i]  <= nx_dly[i];
          ac_gain[i] <= nx_gain[i];
        end
      end
    end
  end

  // circular delay line
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) dline[i] <= '0;
      wptr <= '0;
    end else if (accept) begin
      dline[wptr] <= in_sym;
      wptr        <= wptr + DW'(1);
    end
  end

  // tap accumulation and scaling
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base <= '0;
      k    <= '0;
      acc  <= '0;
      s    <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          base <= wptr;
          k    <= '0;
          acc  <= '0;
        end
        ACCUM: begin
          acc <= acc + AW'(prod);
          k   <= k + KW'(1);
        end
        SCALE:   s <= shifted + SW'(noise);
        default: ;
      endcase
    end
  end

  // saturation
  always_comb begin
    clamp  = sx[OUT_W-1:0];
    sat_nx = 1'b0;
    if (sx > MAXV) begin
      clamp  = MAXV[OUT_W-1:0];
      sat_nx = 1'b1;
    end else if (sx < MINV) begin
      clamp  = MINV[OUT_W-1:0];
      sat_nx = 1'b1;
    end
  end

  // output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid  <= 1'b0;
      out_sample <= '0;
      sat_flag   <= 1'b0;
    end else begin
      out_valid <= (state == OUT);
      if (state == OUT) begin
        out_sample <= clamp;
        sat_flag   <= sat_nx;
      end
    end
  end

`ifdef MULTIPATH_NOISE_EN
  logic [15:0] lfsr;

  assign noise = lfsr[NOISE_W-1:0];

  // noise LFSR, steps once per output
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            lfsr <= LFSR_SEED;
    else if (state == OUT) lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5],
                                    lfsr[15:1]};
  end
`else
  assign noise = '0;
`endif

endmodule

// File: tb/tb_multipath_channel.sv
// tb_multipath_channel: directed stimulus with a scoreboard queue per DUT;
// monitors pop and compare value, sat flag and arrival cycle.
module tb_multipath_channel;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              in_valid, in_ready, cfg_we, out_valid, sat_flag;
  logic signed [1:0] in_sym;
  logic [1:0]        cfg_tap;
  logic [3:0]        cfg_delay;
  logic signed [7:0] cfg_gain;
  logic signed [13:0] out_sample;

  logic              n_in_valid, n_in_ready, n_cfg_we, n_out_valid, n_sat_flag;
  logic signed [1:0] n_in_sym;
  logic [1:0]        n_cfg_tap;
  logic [3:0]        n_cfg_delay;
  logic signed [7:0] n_cfg_gain;
  logic signed [3:0] n_out_sample;

  multipath_channel dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_sym(in_sym),
    .cfg_we(cfg_we), .cfg_tap(cfg_tap),
    .cfg_delay(cfg_delay), .cfg_gain(cfg_gain),
    .out_valid(out_valid), .out_sample(out_sample),
    .sat_flag(sat_flag)
  );

  multipath_channel #(.OUT_W(4)) dut_n (
    .clk(clk), .reset(reset),
    .in_valid(n_in_valid), .in_ready(n_in_ready), .in_sym(n_in_sym),
    .cfg_we(n_cfg_we), .cfg_tap(n_cfg_tap),
    .cfg_delay(n_cfg_delay), .cfg_gain(n_cfg_gain),
    .out_valid(n_out_valid), .out_sample(n_out_sample),
    .sat_flag(n_sat_flag)
  );

  typedef struct {
    int sample;
    bit sat;
    int cyc;
  } exp_t;

  exp_t q_main[$];
  exp_t q_nar[$];
  exp_t em, en;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  bit        pc_en = 1'b0;
  int        pc_tap, pc_delay, pc_gain;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, int act, int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endfunction

  always @(negedge clk) begin
    if (out_valid) begin
      if (q_main.size() == 0) begin
        chk("main_unexpected_out", int'(out_sample), 9999);
      end else begin
        em = q_main.pop_front();
        chk("main_sample", int'(out_sample), em.sample);
        chk("main_sat", int'(sat_flag), int'(em.sat));
        chk("main_cycle", cyc, em.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (n_out_valid) begin
      if (q_nar.size() == 0) begin
        chk("nar_unexpected_out", int'(n_out_sample), 9999);
      end else begin
        en = q_nar.pop_front();
        chk("nar_sample", int'(n_out_sample), en.sample);
        chk("nar_sat", int'(n_sat_flag), int'(en.sat));
        chk("nar_cycle", cyc, en.cyc);
      end
    end
  end

  task automatic cfg(input bit nar, input int tap, input int dly,
                     input int gain);
    @(negedge clk);
    if (nar) begin
      n_cfg_we = 1'b1; n_cfg_tap = 2'(tap);
      n_cfg_delay = 4'(dly); n_cfg_gain = 8'(gain);
    end else begin
      cfg_we = 1'b1; cfg_tap = 2'(tap);
      cfg_delay = 4'(dly); cfg_gain = 8'(gain);
    end
    @(negedge clk);
    cfg_we   = 1'b0;
    n_cfg_we = 1'b0;
  endtask

  task automatic send(input bit nar, input int sym, input int exp_s,
                      input bit exp_sat, input bit push);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    if (nar) begin
      n_in_valid = 1'b1; n_in_sym = 2'(sym);
    end else begin
      in_valid = 1'b1; in_sym = 2'(sym);
      if (pc_en) begin
        cfg_we = 1'b1; cfg_tap = 2'(pc_tap);
        cfg_delay = 4'(pc_delay); cfg_gain = 8'(pc_gain);
      end
    end
    while (!(nar ? n_in_ready : in_ready)) begin
      n++;
      if (n > 50) begin
        chk("send_ready_timeout", 0, 1);
        in_valid = 1'b0; n_in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    e.sample = exp_s;
    e.sat    = exp_sat;
    e.cyc    = cyc + 7;
    if (push) begin
      if (nar) q_nar.push_back(e);
      else     q_main.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; n_in_valid = 1'b0;
    cfg_we = 1'b0; pc_en = 1'b0;
    chk(nar ? "nar_busy_ready" : "busy_ready",
        int'(nar ? n_in_ready : in_ready), 0);
  endtask

  task automatic drain();
    int n = 0;
    while (q_main.size() != 0 || q_nar.size() != 0) begin
      n++;
      if (n > 200) begin
        chk("drain_timeout", q_main.size() + q_nar.size(), 0);
        q_main.delete();
        q_nar.delete();
        break;
      end
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    in_valid = 0; in_sym = 0; cfg_we = 0;
    cfg_tap = 0; cfg_delay = 0; cfg_gain = 0;
    n_in_valid = 0; n_in_sym = 0; n_cfg_we = 0;
    n_cfg_tap = 0; n_cfg_delay = 0; n_cfg_gain = 0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_sample", int'(out_sample), 0);
    chk("rst_sat_flag", int'(sat_flag), 0);
    chk("rst_nar_sample", int'(n_out_sample), 0);
    reset = 1'b1;

`ifdef MULTIPATH_NOISE_EN
    send(0, 0, -31, 0, 1);
    send(0, 0, -16, 0, 1);
    drain();
`else
    send(0, 1, 1, 0, 1);
    send(0, -2, -2, 0, 1);
    send(0, 0, 0, 0, 1);
    drain();

    do_reset();
    cfg(0, 1, 5, -32);
    send(0, 1, 1, 0, 1);
    for (int i = 0; i < 4; i++) send(0, 0, 0, 0, 1);
    send(0, 0, -1, 0, 1);
    drain();

    do_reset();
    cfg(0, 0, 15, 64);
    send(0, 1, 0, 0, 1);
    for (int i = 2; i <= 17; i++) send(0, 0, (i == 16) ? 1 : 0, 0, 1);
    drain();
    send(0, 1, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_in_ready", int'(in_ready), 1);
    repeat (12) @(negedge clk);
    send(0, 1, 1, 0, 1);
    drain();

    do_reset();
    pc_en = 1'b1; pc_tap = 0; pc_delay = 0; pc_gain = -64;
    send(0, 1, -1, 0, 1);
    send(0, -2, 2, 0, 1);
    cfg(0, 0, 0, 96);
    send(0, 1, 1, 0, 1);
    drain();

    for (int t = 0; t < 4; t++) cfg(1, t, 0, 127);
    send(1, -2, -8, 1, 1);
    send(1, 0, 0, 0, 1);
    send(1, 1, 7, 0, 1);
    send(1, -1, -8, 0, 1);
    for (int t = 0; t < 4; t++) cfg(1, t, 0, -128);
    send(1, -2, 7, 1, 1);
    send(1, 1, -8, 0, 1);
    drain();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
